// File: rtl/imm_pkg.sv
// Shared types and constants for the pipelined immediate generator.
package imm_pkg;

    localparam int unsigned XLEN_MAX = 64;
    localparam int unsigned FMT_W    = 3;
    localparam int unsigned OPC_W    = 7;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_ISH  = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } imm_fmt_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_OP        = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [OPC_W-1:0] OPC_FENCE     = 7'b0001111;

    // Fields are sized for the widest datapath; narrower instances use the low bits.
    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        imm_fmt_e            fmt;
        logic [XLEN_MAX-1:0] target;
        logic                target_valid;
        logic                illegal;
    } imm_bundle_t;

    // funct3 values 001/101 select the shift-immediate encodings.
    function automatic logic is_shift_f3(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode, sign extension and pc+imm precompute.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          EN_TARGET = 1'b1
) (
    input  logic [31:0]     inst_code,
    input  logic [XLEN-1:0] in_pc,
    output imm_bundle_t     bundle
);

    logic [OPC_W-1:0] opcode;
    logic [2:0]       funct3;
    logic [5:0]       shamt_op;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  target;
    imm_fmt_e         fmt;
    logic             target_valid;
    logic             illegal;

    assign opcode   = inst_code[6:0];
    assign funct3   = inst_code[14:12];
    // RV64 shifts take a 6-bit shamt; inst[30] only selects arithmetic vs logical.
    assign shamt_op = (XLEN == 64) ? inst_code[25:20] : {1'b0, inst_code[24:20]};

    // Opcode table: format, sign-extended immediate and legality.
    always_comb begin
        imm          = '0;
        fmt          = FMT_NONE;
        target_valid = 1'b0;
        illegal      = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                fmt = FMT_I;
                imm = XLEN'($signed(inst_code[31:20]));
            end
            OPC_OP_IMM: begin
                if (is_shift_f3(funct3)) begin
                    fmt = FMT_ISH;
                    imm = XLEN'(shamt_op);
                end else begin
                    fmt = FMT_I;
                    imm = XLEN'($signed(inst_code[31:20]));
                end
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    if (is_shift_f3(funct3)) begin
                        fmt = FMT_ISH;
                        imm = XLEN'(inst_code[24:20]);
                    end else begin
                        fmt = FMT_I;
                        imm = XLEN'($signed(inst_code[31:20]));
                    end
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = XLEN'($signed({inst_code[31:25], inst_code[11:7]}));
            end
            OPC_BRANCH: begin
                fmt          = FMT_B;
                target_valid = 1'b1;
                imm = XLEN'($signed({inst_code[31], inst_code[7], inst_code[30:25],
                                     inst_code[11:8], 1'b0}));
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt          = FMT_U;
                target_valid = (opcode == OPC_AUIPC);
                imm = XLEN'($signed({inst_code[31:12], 12'b0}));
            end
            OPC_JAL: begin
                fmt          = FMT_J;
                target_valid = 1'b1;
                imm = XLEN'($signed({inst_code[31], inst_code[19:12], inst_code[20],
                                     inst_code[30:21], 1'b0}));
            end
            OPC_OP, OPC_SYSTEM, OPC_FENCE: begin
                fmt = FMT_NONE;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Target is formed for every format; target_valid alone qualifies it.
    assign target = EN_TARGET ? (in_pc + imm) : '0;

    // Pack into the wide bundle with zero upper bits.
    always_comb begin
        bundle              = '0;
        bundle.imm          = XLEN_MAX'(imm);
        bundle.fmt          = fmt;
        bundle.target       = XLEN_MAX'(target);
        bundle.target_valid = target_valid;
        bundle.illegal      = illegal;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a two-entry valid/ready skid buffer.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          EN_TARGET = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst_code,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [FMT_W-1:0] imm_fmt,
    output logic [XLEN-1:0]  out_target,
    output logic             target_valid,
    output logic             illegal
);

    skid_state_e state;
    skid_state_e state_next;
    imm_bundle_t dec;
    imm_bundle_t out_q;
    imm_bundle_t skid_q;
    logic        accept;
    logic        consume;
    logic        load_out_new;
    logic        load_out_skid;
    logic        load_skid;

    imm_decode #(
        .XLEN      (XLEN),
        .EN_TARGET (EN_TARGET)
    ) u_decode (
        .inst_code (inst_code),
        .in_pc     (in_pc),
        .bundle    (dec)
    );

    // Skid state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SKID_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state from handshake; flush empties the buffer.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: if (accept) state_next = SKID_ONE;
                SKID_ONE: begin
                    if (accept && !consume)      state_next = SKID_TWO;
                    else if (consume && !accept) state_next = SKID_EMPTY;
                end
                SKID_TWO:   if (consume) state_next = SKID_ONE;
                default:    state_next = SKID_EMPTY;
            endcase
        end
    end

    // Handshake outputs and register load enables, all decoded from registered state.
    always_comb begin
        in_ready      = (state != SKID_TWO);
        out_valid     = (state != SKID_EMPTY);
        accept        = in_valid && in_ready;
        consume       = out_valid && out_ready;
        load_out_new  = !flush && accept &&
                        ((state == SKID_EMPTY) || ((state == SKID_ONE) && consume));
        load_out_skid = !flush && (state == SKID_TWO) && consume;
        load_skid     = !flush && accept && (state == SKID_ONE) && !consume;
    end

    // Output and skid bundle registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_new) begin
                out_q <= dec;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    assign imm_out      = out_q.imm[XLEN-1:0];
    assign imm_fmt      = FMT_W'(out_q.fmt);
    assign out_target   = out_q.target[XLEN-1:0];
    assign target_valid = out_q.target_valid;
    assign illegal      = out_q.illegal;

    // Upper bundle bits are never driven out on narrow datapaths.
    if (XLEN < XLEN_MAX) begin : g_narrow
        logic unused_hi;
        assign unused_hi = ^{out_q.imm[XLEN_MAX-1:XLEN], out_q.target[XLEN_MAX-1:XLEN]};
    end

endmodule
